id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode/operand-fetch stage directly upstream of the execute/memory stage.
- Accepts a 16-bit instruction and PC from fetch over a valid/ready handshake.
- Holds the 8x16 register file (written by writeback), decodes fields, reads operands and presents a registered ID/EX bundle to execute.
- Inserts load-use bubbles and squashes on redirect.

Parameters:
- NREGS, 8, number of architectural registers; r0 reads zero.
- PCW, 32, PC width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  stage accepts the instruction this cycle.
- if_inst  in  16  instruction word.
- if_pc  in  PCW  PC of if_inst.
- flush  in  1  execute redirect (taken bne/jmp/jr); kill held and incoming instruction.
- ex_stall  in  1  execute cannot accept; hold all ex_* outputs.
- wb_regwrite  in  1  writeback enable.
- wb_waddr  in  3  writeback register.
- wb_wdata  in  16  writeback data.
- ex_valid  out  1  bundle is a real instruction.
- ex_reg1data, ex_reg2data  out  16  operands rs, rt.
- ex_jtarget  out  8; ex_idata  out  8; ex_memaddr  out  6; ex_boffset  out  5.
- ex_funct  out  3; ex_op  out  2; ex_shamt  out  2; ex_rd  out  3.
- ex_bne, ex_jr, ex_jmp, ex_memread, ex_memwrite, ex_memenable, ex_memselect, ex_datamemwrite  out  1 each.
- ex_pc  out  PCW.

Behaviour:
- Encoding, op=inst[15:14]:
  - 00 R: rd[13:11], rs[10:8], rt[7:5], shamt[4:3], funct[2:0].
  - 01 I: funct[13:11], rd[10:8], idata[7:0]; rs=rd.
  - 10 M: inst[13]=write, rd[12:10] (store data reg for writes), memaddr[5:0].
  - 11 B/J: funct[13:11]: 000 bne (rs[10:8], rt[7:5], boffset[4:0]); 001 jmp (jtarget[7:0]); 010 jr (rs[10:8]); others = nop.
- Unused fields drive 0.
- Decoded flags:
  - bne/jmp/jr from op 11.
  - memread = M & ~inst[13]; memwrite = M & inst[13].
  - memenable = memselect = memread|memwrite; datamemwrite = memwrite.
- Register file:
  - Write on clk rise when wb_regwrite and wb_waddr!=0.
  - Reads are combinational with write-through bypass: same-cycle write to a read address returns wb_wdata.
  - r0 always reads 0.
  - Contents not cleared by reset.
- Latency: one cycle. Accepted instruction appears on ex_* at the next edge.
- Handshake:
  - Transfer when if_valid & if_ready.
  - if_ready = ~ex_stall & ~hazard & ~flush.
- Load-use hazard: held bundle has ex_valid & ex_memread, and ex_rd equals a source register of if_inst that is actually used (R: rs,rt; I: rs; bne: rs,rt; jr: rs; M write: rd), with nonzero address.
  - Effect: if_ready=0 and a bubble is loaded next edge, so exactly one bubble per hazard.
- Bubble / nop bundle:
  - ex_valid=0, ex_op=11, ex_funct=111.
  - All flags 0, data fields 0, ex_pc unchanged.
  - op=11 keeps the execute-side regwrite low.
- Priority at each edge: reset > ex_stall (hold everything, including held bubble) > flush (load bubble) > hazard (load bubble) > transfer (load decode) > no if_valid (load bubble).
- flush together with ex_stall: the stall holds the bundle. The flush must be reasserted by the execute stage; it is not remembered.
- Reset (async assert, sync release, asserted while rst=0):
  - All ex_* outputs take nop-bundle values, with ex_pc=0.
  - if_ready=0 during reset.
  - Mid-operation reset discards the held instruction.

Test Plan:
- Reset then write r3=16'h00A5 via wb; issue R add rd=1,rs=3,rt=0 (inst 16'h0B00) -> next cycle ex_valid=1, ex_reg1data=00A5, ex_reg2data=0000, ex_rd=1, ex_op=00.
- wb writes r2=1234 in the same cycle as inst with rs=2 is accepted -> ex_reg1data=1234 (bypass); write to r0 -> r0 still reads 0.
- Load r4 from addr 6'h15 (inst 16'h9015), then R inst using rs=4 -> one cycle if_ready=0, one bubble (ex_valid=0, ex_op=11), then the R inst issues; a non-dependent follower issues with no bubble.
- jmp jtarget=8'h40 (inst 16'hC840) -> ex_jmp=1, ex_jtarget=40; assert flush next cycle with if_valid=1 -> if_ready=0, bubble loaded.
- ex_stall high 3 cycles with if_valid=1 -> ex_* outputs constant, if_ready=0, no instruction lost after release.
- Drop rst mid-stream while ex_memwrite=1 -> all ex_* outputs go to nop values immediately (no clock edge needed).

Source files
------------

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
//
// Decode / operand-fetch stage sitting directly in front of execute/memory.
// Takes a 16-bit instruction and its PC from fetch over a valid/ready
// handshake, decodes the fields, reads operands from the 8x16 register file
// (written by writeback) and presents a registered ID/EX bundle to execute.
// Load-use hazards insert exactly one bubble; an execute redirect (flush)
// squashes the incoming instruction and loads a bubble instead.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   if_valid/_ready/_inst/_pc   fetch handshake, instruction word and PC
//   flush          execute redirect, kills incoming instruction
//   ex_stall       execute cannot accept, hold the whole bundle
//   wb_regwrite/_waddr/_wdata   register file write port
//   ex_*           registered decode bundle for execute
// -----------------------------------------------------------------------------
module id_stage #(
  parameter int NREGS = 8,
  parameter int PCW   = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_valid,
  output logic           if_ready,
  input  logic [15:0]    if_inst,
  input  logic [PCW-1:0] if_pc,
  input  logic           flush,
  input  logic           ex_stall,
  input  logic           wb_regwrite,
  input  logic [2:0]     wb_waddr,
  input  logic [15:0]    wb_wdata,
  output logic           ex_valid,
  output logic [15:0]    ex_reg1data,
  output logic [15:0]    ex_reg2data,
  output logic [7:0]     ex_jtarget,
  output logic [7:0]     ex_idata,
  output logic [5:0]     ex_memaddr,
  output logic [4:0]     ex_boffset,
  output logic [2:0]     ex_funct,
  output logic [1:0]     ex_op,
  output logic [1:0]     ex_shamt,
  output logic [2:0]     ex_rd,
  output logic           ex_bne,
  output logic           ex_jr,
  output logic           ex_jmp,
  output logic           ex_memread,
  output logic           ex_memwrite,
  output logic           ex_memenable,
  output logic           ex_memselect,
  output logic           ex_datamemwrite,
  output logic [PCW-1:0] ex_pc
);

  typedef struct packed {
    logic           valid;
    logic [15:0]    reg1data;
    logic [15:0]    reg2data;
    logic [7:0]     jtarget;
    logic [7:0]     idata;
    logic [5:0]     memaddr;
    logic [4:0]     boffset;
    logic [2:0]     funct;
    logic [1:0]     op;
    logic [1:0]     shamt;
    logic [2:0]     rd;
    logic           bne;
    logic           jr;
    logic           jmp;
    logic           memread;
    logic           memwrite;
    logic           memenable;
    logic           memselect;
    logic           datamemwrite;
    logic [PCW-1:0] pc;
  } bundle_t;

  logic [15:0] rf_q [NREGS];

  bundle_t bundle_q;
  bundle_t bundle_d;
  bundle_t decBundle;
  bundle_t nopBundle;

  logic [2:0]  rsAddr;
  logic [2:0]  rtAddr;
  logic [15:0] rsData;
  logic [15:0] rtData;
  logic        hazard;

  // Register file write port. Contents are deliberately not reset; r0 is
  // never written so it can be treated as a constant zero on the read side.
  always_ff @(posedge clk) begin
    if (wb_regwrite && (wb_waddr != 3'd0)) begin
      rf_q[wb_waddr] <= wb_wdata;
    end
  end

  // Source register addresses. A source that the instruction does not use is
  // forced to r0, so its operand reads as zero and it can never match a
  // pending load destination in the hazard check.
  always_comb begin
    rsAddr = 3'd0;
    rtAddr = 3'd0;
    case (if_inst[15:14])
      2'b00: begin
        rsAddr = if_inst[10:8];
        rtAddr = if_inst[7:5];
      end
      2'b01: begin
        rsAddr = if_inst[10:8];
      end
      2'b10: begin
        // Stores read their data register through the rs port.
        if (if_inst[13]) begin
          rsAddr = if_inst[12:10];
        end
      end
      default: begin
        if (if_inst[13:11] == 3'b000) begin
          rsAddr = if_inst[10:8];
          rtAddr = if_inst[7:5];
        end else if (if_inst[13:11] == 3'b010) begin
          rsAddr = if_inst[10:8];
        end
      end
    endcase
  end

  // Combinational reads with write-through bypass from writeback.
  always_comb begin
    rsData = 16'h0000;
    if (rsAddr != 3'd0) begin
      if (wb_regwrite && (wb_waddr == rsAddr)) begin
        rsData = wb_wdata;
      end else begin
        rsData = rf_q[rsAddr];
      end
    end
  end

  always_comb begin
    rtData = 16'h0000;
    if (rtAddr != 3'd0) begin
      if (wb_regwrite && (wb_waddr == rtAddr)) begin
        rtData = wb_wdata;
      end else begin
        rtData = rf_q[rtAddr];
      end
    end
  end

  // Field decode of the incoming instruction into a full bundle.
  always_comb begin
    decBundle          = '0;
    decBundle.valid    = 1'b1;
    decBundle.pc       = if_pc;
    decBundle.reg1data = rsData;
    decBundle.reg2data = rtData;
    decBundle.op       = if_inst[15:14];
    case (if_inst[15:14])
      2'b00: begin
        decBundle.rd    = if_inst[13:11];
        decBundle.shamt = if_inst[4:3];
        decBundle.funct = if_inst[2:0];
      end
      2'b01: begin
        decBundle.funct = if_inst[13:11];
        decBundle.rd    = if_inst[10:8];
        decBundle.idata = if_inst[7:0];
      end
      2'b10: begin
        decBundle.rd       = if_inst[12:10];
        decBundle.memaddr  = if_inst[5:0];
        decBundle.memread  = ~if_inst[13];
        decBundle.memwrite = if_inst[13];
      end
      default: begin
        decBundle.funct = if_inst[13:11];
        case (if_inst[13:11])
          3'b000: begin
            decBundle.bne     = 1'b1;
            decBundle.boffset = if_inst[4:0];
          end
          3'b001: begin
            decBundle.jmp     = 1'b1;
            decBundle.jtarget = if_inst[7:0];
          end
          3'b010: begin
            decBundle.jr = 1'b1;
          end
          default: begin
          end
        endcase
      end
    endcase
    decBundle.memenable    = decBundle.memread | decBundle.memwrite;
    decBundle.memselect    = decBundle.memread | decBundle.memwrite;
    decBundle.datamemwrite = decBundle.memwrite;
  end

  // Bubble: op=11/funct=111 keeps execute from writing back; PC is kept.
  always_comb begin
    nopBundle       = '0;
    nopBundle.op    = 2'b11;
    nopBundle.funct = 3'b111;
    nopBundle.pc    = bundle_q.pc;
  end

  // A held load whose destination feeds a used source of the incoming
  // instruction cannot be forwarded in time; the bubble it causes clears
  // ex_valid, so the hazard lasts exactly one cycle.
  always_comb begin
    hazard = 1'b0;
    if (if_valid && bundle_q.valid && bundle_q.memread && (bundle_q.rd != 3'd0)) begin
      hazard = (bundle_q.rd == rsAddr) || (bundle_q.rd == rtAddr);
    end
  end

  assign if_ready = rst & ~ex_stall & ~hazard & ~flush;

  // Next bundle: stall holds everything, then flush, hazard and an empty
  // fetch slot all load a bubble, otherwise the decoded instruction.
  always_comb begin
    bundle_d = bundle_q;
    if (ex_stall) begin
      bundle_d = bundle_q;
    end else if (flush || hazard || !if_valid) begin
      bundle_d = nopBundle;
    end else begin
      bundle_d = decBundle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bundle_q       <= '0;
      bundle_q.op    <= 2'b11;
      bundle_q.funct <= 3'b111;
    end else begin
      bundle_q <= bundle_d;
    end
  end

  assign ex_valid        = bundle_q.valid;
  assign ex_reg1data     = bundle_q.reg1data;
  assign ex_reg2data     = bundle_q.reg2data;
  assign ex_jtarget      = bundle_q.jtarget;
  assign ex_idata        = bundle_q.idata;
  assign ex_memaddr      = bundle_q.memaddr;
  assign ex_boffset      = bundle_q.boffset;
  assign ex_funct        = bundle_q.funct;
  assign ex_op           = bundle_q.op;
  assign ex_shamt        = bundle_q.shamt;
  assign ex_rd           = bundle_q.rd;
  assign ex_bne          = bundle_q.bne;
  assign ex_jr           = bundle_q.jr;
  assign ex_jmp          = bundle_q.jmp;
  assign ex_memread      = bundle_q.memread;
  assign ex_memwrite     = bundle_q.memwrite;
  assign ex_memenable    = bundle_q.memenable;
  assign ex_memselect    = bundle_q.memselect;
  assign ex_datamemwrite = bundle_q.datamemwrite;
  assign ex_pc           = bundle_q.pc;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
//
// Directed testbench for id_stage: reset values, basic decode, register file
// bypass and r0, load-use bubble, jump plus flush, execute stall and
// asynchronous mid-stream reset.
// -----------------------------------------------------------------------------
module tb_id_stage;

  localparam int PCW = 32;

  logic           clk;
  logic           rst;
  logic           if_valid;
  logic           if_ready;
  logic [15:0]    if_inst;
  logic [PCW-1:0] if_pc;
  logic           flush;
  logic           ex_stall;
  logic           wb_regwrite;
  logic [2:0]     wb_waddr;
  logic [15:0]    wb_wdata;
  logic           ex_valid;
  logic [15:0]    ex_reg1data;
  logic [15:0]    ex_reg2data;
  logic [7:0]     ex_jtarget;
  logic [7:0]     ex_idata;
  logic [5:0]     ex_memaddr;
  logic [4:0]     ex_boffset;
  logic [2:0]     ex_funct;
  logic [1:0]     ex_op;
  logic [1:0]     ex_shamt;
  logic [2:0]     ex_rd;
  logic           ex_bne;
  logic           ex_jr;
  logic           ex_jmp;
  logic           ex_memread;
  logic           ex_memwrite;
  logic           ex_memenable;
  logic           ex_memselect;
  logic           ex_datamemwrite;
  logic [PCW-1:0] ex_pc;

  int checks;
  int fails;

  id_stage #(.NREGS(8), .PCW(PCW)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .flush(flush), .ex_stall(ex_stall),
    .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_valid(ex_valid), .ex_reg1data(ex_reg1data), .ex_reg2data(ex_reg2data),
    .ex_jtarget(ex_jtarget), .ex_idata(ex_idata), .ex_memaddr(ex_memaddr),
    .ex_boffset(ex_boffset), .ex_funct(ex_funct), .ex_op(ex_op),
    .ex_shamt(ex_shamt), .ex_rd(ex_rd), .ex_bne(ex_bne), .ex_jr(ex_jr),
    .ex_jmp(ex_jmp), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memenable(ex_memenable), .ex_memselect(ex_memselect),
    .ex_datamemwrite(ex_datamemwrite), .ex_pc(ex_pc)
  );

  // 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a broken design can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_valid = 1'b0; if_inst = 16'h0000; if_pc = '0;
    flush = 1'b0; ex_stall = 1'b0;
    wb_regwrite = 1'b0; wb_waddr = 3'd0; wb_wdata = 16'h0000;
    tick(); tick();
    checks++;
    if ({ex_valid, ex_op, ex_funct} !== 6'b0_11_111) begin
      fails++;
      $display("[TB] FAIL reset_nop: got %b required %b", {ex_valid, ex_op, ex_funct}, 6'b0_11_111);
    end
    checks++;
    if (ex_pc !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_pc: got %h required 0", ex_pc);
    end
    checks++;
    if ({ex_bne, ex_jr, ex_jmp, ex_memread, ex_memwrite, ex_memenable, ex_memselect, ex_datamemwrite} !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b required 00000000",
               {ex_bne, ex_jr, ex_jmp, ex_memread, ex_memwrite, ex_memenable, ex_memselect, ex_datamemwrite});
    end
    checks++;
    if ({ex_reg1data, ex_reg2data, ex_jtarget, ex_idata, ex_memaddr, ex_boffset, ex_shamt, ex_rd} !== 66'h0) begin
      fails++;
      $display("[TB] FAIL reset_data: got %h required 0",
               {ex_reg1data, ex_reg2data, ex_jtarget, ex_idata, ex_memaddr, ex_boffset, ex_shamt, ex_rd});
    end
    checks++;
    if (if_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ready: got %b required 0", if_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (if_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_after_reset: got %b required 1", if_ready);
    end
  endtask

  task automatic test_basic_decode();
    // Write r3 = 00A5, then issue add r1 = r3 + r0
    wb_regwrite = 1'b1; wb_waddr = 3'd3; wb_wdata = 16'h00A5;
    tick();
    wb_regwrite = 1'b0;
    if_valid = 1'b1; if_inst = 16'h0B00; if_pc = 32'h100;
    tick();
    if_valid = 1'b0;
    checks++;
    if ({ex_valid, ex_op, ex_rd} !== {1'b1, 2'b00, 3'd1}) begin
      fails++;
      $display("[TB] FAIL basic_ctrl: got %b required %b", {ex_valid, ex_op, ex_rd}, {1'b1, 2'b00, 3'd1});
    end
    checks++;
    if ({ex_reg1data, ex_reg2data} !== {16'h00A5, 16'h0000}) begin
      fails++;
      $display("[TB] FAIL basic_operands: got %h required %h", {ex_reg1data, ex_reg2data}, {16'h00A5, 16'h0000});
    end
    checks++;
    if (ex_pc !== 32'h100) begin
      fails++;
      $display("[TB] FAIL basic_pc: got %h required 00000100", ex_pc);
    end
  endtask

  task automatic test_bypass();
    // r2 written in the same cycle an instruction reading rs=2, rt=3 issues
    wb_regwrite = 1'b1; wb_waddr = 3'd2; wb_wdata = 16'h1234;
    if_valid = 1'b1; if_inst = 16'h2A60; if_pc = 32'h104;
    tick();
    checks++;
    if ({ex_reg1data, ex_reg2data, ex_rd} !== {16'h1234, 16'h00A5, 3'd5}) begin
      fails++;
      $display("[TB] FAIL bypass: got %h required %h", {ex_reg1data, ex_reg2data, ex_rd}, {16'h1234, 16'h00A5, 3'd5});
    end
    // A write to r0 must neither bypass nor stick
    wb_waddr = 3'd0; wb_wdata = 16'hFFFF;
    if_inst = 16'h0800; if_pc = 32'h106;
    tick();
    checks++;
    if (ex_reg1data !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL r0_bypass: got %h required 0000", ex_reg1data);
    end
    wb_regwrite = 1'b0;
    tick();
    checks++;
    if (ex_reg1data !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL r0_stored: got %h required 0000", ex_reg1data);
    end
    // r2 really landed in the register file
    if_inst = 16'h0A00; if_pc = 32'h108;
    tick();
    if_valid = 1'b0;
    checks++;
    if (ex_reg1data !== 16'h1234) begin
      fails++;
      $display("[TB] FAIL r2_stored: got %h required 1234", ex_reg1data);
    end
  endtask

  task automatic test_load_use();
    if_valid = 1'b1; if_inst = 16'h9015; if_pc = 32'h110;
    tick();
    checks++;
    if ({ex_valid, ex_op, ex_rd, ex_memaddr} !== {1'b1, 2'b10, 3'd4, 6'h15}) begin
      fails++;
      $display("[TB] FAIL load_fields: got %h required %h", {ex_valid, ex_op, ex_rd, ex_memaddr}, {1'b1, 2'b10, 3'd4, 6'h15});
    end
    checks++;
    if ({ex_memread, ex_memwrite, ex_memenable, ex_memselect, ex_datamemwrite} !== 5'b10110) begin
      fails++;
      $display("[TB] FAIL load_flags: got %b required 10110",
               {ex_memread, ex_memwrite, ex_memenable, ex_memselect, ex_datamemwrite});
    end
    // Dependent instruction reads r4
    if_inst = 16'h0C00; if_pc = 32'h112;
    #1;
    checks++;
    if (if_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL hazard_ready: got %b required 0", if_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_op, ex_funct, ex_memread} !== 7'b0_11_111_0) begin
      fails++;
      $display("[TB] FAIL hazard_bubble: got %b required 0111110", {ex_valid, ex_op, ex_funct, ex_memread});
    end
    checks++;
    if (ex_pc !== 32'h110) begin
      fails++;
      $display("[TB] FAIL bubble_pc: got %h required 00000110", ex_pc);
    end
    checks++;
    if (if_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL hazard_release: got %b required 1", if_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_op, ex_rd, ex_pc} !== {1'b1, 2'b00, 3'd1, 32'h112}) begin
      fails++;
      $display("[TB] FAIL dependent_issue: got %h required %h", {ex_valid, ex_op, ex_rd, ex_pc}, {1'b1, 2'b00, 3'd1, 32'h112});
    end
    // Load r5 followed by an independent reader of r3: no bubble
    if_inst = 16'h9415; if_pc = 32'h114;
    tick();
    if_inst = 16'h0B00; if_pc = 32'h116;
    #1;
    checks++;
    if (if_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL nodep_ready: got %b required 1", if_ready);
    end
    tick();
    if_valid = 1'b0;
    checks++;
    if ({ex_valid, ex_pc, ex_reg1data} !== {1'b1, 32'h116, 16'h00A5}) begin
      fails++;
      $display("[TB] FAIL nodep_issue: got %h required %h", {ex_valid, ex_pc, ex_reg1data}, {1'b1, 32'h116, 16'h00A5});
    end
  endtask

  task automatic test_jump_flush();
    if_valid = 1'b1; if_inst = 16'hC840; if_pc = 32'h120;
    tick();
    checks++;
    if ({ex_valid, ex_op, ex_funct, ex_jmp, ex_bne, ex_jr, ex_jtarget} !== {1'b1, 2'b11, 3'b001, 3'b100, 8'h40}) begin
      fails++;
      $display("[TB] FAIL jmp_decode: got %h required %h",
               {ex_valid, ex_op, ex_funct, ex_jmp, ex_bne, ex_jr, ex_jtarget}, {1'b1, 2'b11, 3'b001, 3'b100, 8'h40});
    end
    flush = 1'b1; if_inst = 16'h0B00; if_pc = 32'h122;
    #1;
    checks++;
    if (if_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_ready: got %b required 0", if_ready);
    end
    tick();
    flush = 1'b0; if_valid = 1'b0;
    checks++;
    if ({ex_valid, ex_op, ex_funct, ex_jmp, ex_jtarget} !== {1'b0, 2'b11, 3'b111, 1'b0, 8'h00}) begin
      fails++;
      $display("[TB] FAIL flush_bubble: got %h required %h",
               {ex_valid, ex_op, ex_funct, ex_jmp, ex_jtarget}, {1'b0, 2'b11, 3'b111, 1'b0, 8'h00});
    end
  endtask

  task automatic test_stall();
    if_valid = 1'b1; if_inst = 16'h0B00; if_pc = 32'h200;
    tick();
    ex_stall = 1'b1; if_inst = 16'h0800; if_pc = 32'h204;
    #1;
    checks++;
    if (if_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stall_ready: got %b required 0", if_ready);
    end
    for (int i = 0; i < 3; i++) begin
      // A flush during a stall is not remembered
      flush = (i == 1);
      tick();
      checks++;
      if ({ex_valid, ex_pc, ex_rd, ex_reg1data} !== {1'b1, 32'h200, 3'd1, 16'h00A5}) begin
        fails++;
        $display("[TB] FAIL stall_hold%0d: got %h required %h", i,
                 {ex_valid, ex_pc, ex_rd, ex_reg1data}, {1'b1, 32'h200, 3'd1, 16'h00A5});
      end
    end
    flush = 1'b0; ex_stall = 1'b0;
    #1;
    checks++;
    if (if_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL stall_release: got %b required 1", if_ready);
    end
    tick();
    if_valid = 1'b0;
    checks++;
    if ({ex_valid, ex_pc, ex_rd, ex_reg1data} !== {1'b1, 32'h204, 3'd1, 16'h0000}) begin
      fails++;
      $display("[TB] FAIL stall_nolost: got %h required %h",
               {ex_valid, ex_pc, ex_rd, ex_reg1data}, {1'b1, 32'h204, 3'd1, 16'h0000});
    end
  endtask

  task automatic test_async_reset();
    // Store r3 to address 2A
    if_valid = 1'b1; if_inst = 16'hAC2A; if_pc = 32'h300;
    tick();
    checks++;
    if ({ex_valid, ex_memread, ex_memwrite, ex_memenable, ex_memselect, ex_datamemwrite, ex_memaddr, ex_rd} !==
        {6'b101111, 6'h2A, 3'd3}) begin
      fails++;
      $display("[TB] FAIL store_decode: got %h required %h",
               {ex_valid, ex_memread, ex_memwrite, ex_memenable, ex_memselect, ex_datamemwrite, ex_memaddr, ex_rd},
               {6'b101111, 6'h2A, 3'd3});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({ex_valid, ex_op, ex_funct, ex_memwrite, ex_datamemwrite, ex_memenable} !== 9'b0_11_111_000) begin
      fails++;
      $display("[TB] FAIL async_reset_nop: got %b required 011111000",
               {ex_valid, ex_op, ex_funct, ex_memwrite, ex_datamemwrite, ex_memenable});
    end
    checks++;
    if ({ex_pc, ex_memaddr, ex_rd, if_ready} !== {32'h0, 6'h0, 3'd0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL async_reset_data: got %h required 0", {ex_pc, ex_memaddr, ex_rd, if_ready});
    end
    tick();
    if_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if ({ex_valid, ex_pc} !== {1'b0, 32'h0}) begin
      fails++;
      $display("[TB] FAIL post_reset_idle: got %h required 0", {ex_valid, ex_pc});
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic_decode();
    test_bypass();
    test_load_use();
    test_jump_flush();
    test_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
